// File: rtl/change_dispenser.sv
// change_dispenser: pays a requested rupee amount as 3/2/1 coins through a hopper handshake.
// Define CHANGE_DISP_TOTAL_EN to add the saturating paid_total output.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 15,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] change_in,
  input  logic       change_valid,
  input  logic [2:0] hopper_empty,
  input  logic       eject_ack,
  input  logic       fault_clr,
  output logic       eject_valid,
  output logic [1:0] eject_coin,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] shortfall,
`ifdef CHANGE_DISP_TOTAL_EN
  output logic [7:0] paid_total,
`endif
  output logic       req_dropped
);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FAULT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] LAST_GAP  = 4'(GAP_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] remaining, remaining_next;
  logic [1:0] coin, coin_next;
  logic [7:0] wait_cnt, wait_next;
  logic [3:0] gap_cnt, gap_next;
  logic [3:0] short_q, short_next;
  logic       done_next, dropped_next;
  logic [1:0] pick;

  // Coin codes equal the rupee value, so the code doubles as the subtrahend.
  always_comb begin
    pick = 2'd0;
    if (remaining >= 4'd3 && !hopper_empty[2])
      pick = 2'd3;
    else if (remaining >= 4'd2 && !hopper_empty[1])
      pick = 2'd2;
    else if (remaining >= 4'd1 && !hopper_empty[0])
      pick = 2'd1;
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    coin_next      = coin;
    wait_next      = wait_cnt;
    gap_next       = gap_cnt;
    short_next     = short_q;
    done_next      = 1'b0;
    dropped_next   = change_valid && (state != IDLE);
    case (state)
      IDLE: begin
        if (change_valid && change_in != 4'd0) begin
          remaining_next = change_in;
          state_next     = SELECT;
        end
      end
      SELECT: begin
        if (pick != 2'd0) begin
          coin_next  = pick;
          wait_next  = 8'd0;
          state_next = EJECT;
        end else begin
          short_next = remaining;
          state_next = FAULT;
        end
      end
      EJECT: begin
        // An ack on the final allowed cycle still counts as a successful eject.
        if (eject_ack) begin
          remaining_next = remaining - {2'b00, coin};
          if (remaining == {2'b00, coin}) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else if (GAP_CYCLES == 0) begin
            state_next = SELECT;
          end else begin
            gap_next   = 4'd0;
            state_next = GAP;
          end
        end else if (wait_cnt == LAST_WAIT) begin
          short_next = remaining;
          state_next = FAULT;
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt == LAST_GAP)
          state_next = SELECT;
        else
          gap_next = gap_cnt + 4'd1;
      end
      FAULT: begin
        if (fault_clr) begin
          short_next = 4'd0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= 4'd0;
      coin        <= 2'd0;
      wait_cnt    <= 8'd0;
      gap_cnt     <= 4'd0;
      short_q     <= 4'd0;
      done        <= 1'b0;
      req_dropped <= 1'b0;
    end else begin
      state       <= state_next;
      remaining   <= remaining_next;
      coin        <= coin_next;
      wait_cnt    <= wait_next;
      gap_cnt     <= gap_next;
      short_q     <= short_next;
      done        <= done_next;
      req_dropped <= dropped_next;
    end
  end

  assign busy        = (state == SELECT) || (state == EJECT) || (state == GAP);
  assign eject_valid = (state == EJECT);
  assign eject_coin  = eject_valid ? coin : 2'b00;
  assign fault       = (state == FAULT);
  assign shortfall   = short_q;

`ifdef CHANGE_DISP_TOTAL_EN
  logic [8:0] total_sum;
  assign total_sum = {1'b0, paid_total} + {7'd0, coin};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      paid_total <= 8'd0;
    else if (state == EJECT && eject_ack)
      paid_total <= total_sum[8] ? 8'hFF : total_sum[7:0];
  end
`endif

endmodule
